bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that multiplexes MASTERS requesters onto
// one interconnect master port. Masters are held to MAX_HOLD transfers per
// tenure while others wait. Read data returns one cycle after the address
// and is routed back to the master that issued the read.

// Per-master output slice: grant bit, read-valid bit and read-data slice.
module bus_arbiter_lane #(
  parameter int WIDTH = 32,
  parameter int IW    = 1,
  parameter int IDX   = 0
) (
  input  logic             i_en,
  input  logic             i_busy,
  input  logic [IW-1:0]    i_owner,
  input  logic             i_rpend,
  input  logic [IW-1:0]    i_rowner,
  input  logic [WIDTH-1:0] i_rd_m,
  output logic             o_gnt,
  output logic             o_rvalid,
  output logic [WIDTH-1:0] o_rd
);

  localparam logic [IW-1:0] MY_IDX = IW'(IDX);

  // Grant and read-return decode for this lane; everything is forced low in reset.
  always_comb begin
    o_gnt    = i_en & i_busy & (i_owner == MY_IDX);
    o_rvalid = i_en & i_rpend & (i_rowner == MY_IDX);
    o_rd     = o_rvalid ? i_rd_m : '0;
  end

endmodule

module bus_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MASTERS  = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MASTERS-1:0]       req,
  input  logic [MASTERS-1:0]       we,
  input  logic [MASTERS*WIDTH-1:0] addr,
  input  logic [MASTERS*WIDTH-1:0] wd,
  output logic [MASTERS-1:0]       gnt,
  output logic [MASTERS-1:0]       rvalid,
  output logic [MASTERS*WIDTH-1:0] rd,
  output logic                     we_m,
  output logic [WIDTH-1:0]         addr_m,
  output logic [WIDTH-1:0]         wd_m,
  input  logic [WIDTH-1:0]         rd_m
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(MASTERS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_owner, w_owner_nxt;
  logic [IW-1:0]    r_last, w_last_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic             r_rpend, w_rpend_nxt;
  logic [IW-1:0]    r_rowner, w_rowner_nxt;

  logic             w_busy;
  logic             w_accept;
  logic             w_own_req;
  logic             w_own_we;
  logic [WIDTH-1:0] w_own_addr;
  logic [WIDTH-1:0] w_own_wd;
  logic             w_others;
  logic [IW-1:0]    w_pick;
  logic             w_pick_vld;
  int               w_best;

  assign w_busy   = (r_state == BUSY);
  // Reset masks the accept so nothing reaches the interconnect while rst_n is low.
  assign w_accept = rst_n & w_busy & w_own_req;

  // Select the owner's request fields and note whether anyone else is waiting.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_we   = 1'b0;
    w_own_addr = '0;
    w_own_wd   = '0;
    w_others   = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      if (r_owner == IW'(i)) begin
        w_own_req  = req[i];
        w_own_we   = we[i];
        w_own_addr = addr[WIDTH*i +: WIDTH];
        w_own_wd   = wd[WIDTH*i +: WIDTH];
        w_others   = |(req & ~(MASTERS'(1) << i));
      end
    end
  end

  // Round-robin pick: the requester closest after r_last (distance 0 = last+1) wins.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_best     = MASTERS;
    for (int i = 0; i < MASTERS; i++) begin
      if (req[i] && (((i + MASTERS - 1 - int'(r_last)) % MASTERS) < w_best)) begin
        w_best     = (i + MASTERS - 1 - int'(r_last)) % MASTERS;
        w_pick     = IW'(i);
        w_pick_vld = 1'b1;
      end
    end
  end

  // Next-state logic: arbitration in IDLE, tenure tracking and release in BUSY.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_hold_nxt   = r_hold;
    w_rpend_nxt  = w_accept & ~w_own_we;
    w_rowner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_pick;
          w_last_nxt  = w_pick;
          w_hold_nxt  = '0;
        end
      end
      BUSY: begin
        if (!w_own_req) begin
          w_state_nxt = IDLE;
        end else begin
          if (r_hold != HOLD_MAX) w_hold_nxt = r_hold + 1'b1;
          // Tenure exhausted and someone else is waiting: hand the bus back.
          if ((r_hold == HOLD_MAX) && w_others) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and bookkeeping registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_last   <= LAST_RST;
      r_hold   <= '0;
      r_rpend  <= 1'b0;
      r_rowner <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_hold   <= w_hold_nxt;
      r_rpend  <= w_rpend_nxt;
      r_rowner <= w_rowner_nxt;
    end
  end

  // Interconnect master port: owner's transfer on accept, zero otherwise.
  always_comb begin
    we_m   = w_accept & w_own_we;
    addr_m = w_accept ? w_own_addr : '0;
    wd_m   = w_accept ? w_own_wd : '0;
  end

  for (genvar g = 0; g < MASTERS; g++) begin : g_lane
    bus_arbiter_lane #(
      .WIDTH (WIDTH),
      .IW    (IW),
      .IDX   (g)
    ) u_lane (
      .i_en     (rst_n),
      .i_busy   (w_busy),
      .i_owner  (r_owner),
      .i_rpend  (r_rpend),
      .i_rowner (r_rowner),
      .i_rd_m   (rd_m),
      .o_gnt    (gnt[g]),
      .o_rvalid (rvalid[g]),
      .o_rd     (rd[WIDTH*g +: WIDTH])
    );
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector table on a default 2-master arbiter, then
// hand sequences and randomized traffic on a 3-master, 16-bit arbiter checked
// against a transaction-level reference model.
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT A: default parameters (2 masters, 32 bit, hold 4)
  logic        a_rst_n;
  logic [1:0]  a_req, a_we, a_gnt, a_rv;
  logic [63:0] a_addr, a_wd, a_rd;
  logic        a_we_m;
  logic [31:0] a_addr_m, a_wd_m, a_rd_m;

  bus_arbiter u_dut2 (
    .clk    (clk),
    .rst_n  (a_rst_n),
    .req    (a_req),
    .we     (a_we),
    .addr   (a_addr),
    .wd     (a_wd),
    .gnt    (a_gnt),
    .rvalid (a_rv),
    .rd     (a_rd),
    .we_m   (a_we_m),
    .addr_m (a_addr_m),
    .wd_m   (a_wd_m),
    .rd_m   (a_rd_m)
  );

  // ---------------- DUT B: 3 masters, 16 bit, hold 4
  localparam int M  = 3;
  localparam int W  = 16;
  localparam int H  = 4;
  localparam int MW = M * W;

  logic          b_rst_n;
  logic [M-1:0]  b_req, b_we, b_gnt, b_rv;
  logic [MW-1:0] b_addr, b_wd, b_rd;
  logic          b_we_m;
  logic [W-1:0]  b_addr_m, b_wd_m, b_rd_m;

  bus_arbiter #(.WIDTH(W), .MASTERS(M), .MAX_HOLD(H)) u_dut3 (
    .clk    (clk),
    .rst_n  (b_rst_n),
    .req    (b_req),
    .we     (b_we),
    .addr   (b_addr),
    .wd     (b_wd),
    .gnt    (b_gnt),
    .rvalid (b_rv),
    .rd     (b_rd),
    .we_m   (b_we_m),
    .addr_m (b_addr_m),
    .wd_m   (b_wd_m),
    .rd_m   (b_rd_m)
  );

  // ---------------- vector table for DUT A
  typedef struct {
    logic        rst_n;
    logic [1:0]  req, we;
    logic [31:0] a0, a1, w0, w1, rdm;
    logic [1:0]  gnt, rv;
    logic        wem;
    logic [31:0] am, wdm, rd0, rd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rst_n, input logic [1:0] req, input logic [1:0] we,
    input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] w0,
    input logic [31:0] w1, input logic [31:0] rdm,
    input logic [1:0] gnt, input logic [1:0] rv, input logic wem,
    input logic [31:0] am, input logic [31:0] wdm, input logic [31:0] rd0,
    input logic [31:0] rd1);
    vec_t t;
    t.rst_n = rst_n; t.req = req; t.we = we;
    t.a0 = a0; t.a1 = a1; t.w0 = w0; t.w1 = w1; t.rdm = rdm;
    t.gnt = gnt; t.rv = rv; t.wem = wem;
    t.am = am; t.wdm = wdm; t.rd0 = rd0; t.rd1 = rd1;
    return t;
  endfunction

  localparam logic [31:0] A0 = 32'h100;
  localparam logic [31:0] A1 = 32'h200;

  task automatic fill_table();
    //        rst req    we     a0     a1     w0     w1    rdm            gnt    rv   wem am     wdm    rd0            rd1
    tbl.push_back(v(0, 2'b11, 2'b11, A0,    A1,    1,     2,    0,             2'b00, 2'b00, 0, 0,     0,     0,             0));
    tbl.push_back(v(0, 2'b00, 2'b00, 0,     0,     0,     0,    0,             2'b00, 2'b00, 0, 0,     0,     0,             0));
    // single master write from reset
    tbl.push_back(v(1, 2'b01, 2'b01, 32'h10, 0,    32'hA5, 0,   0,             2'b00, 2'b00, 0, 0,     0,     0,             0));
    tbl.push_back(v(1, 2'b01, 2'b01, 32'h10, 0,    32'hA5, 0,   0,             2'b01, 2'b00, 1, 32'h10, 32'hA5, 0,          0));
    tbl.push_back(v(1, 2'b00, 2'b00, 32'h10, 0,    32'hA5, 0,   0,             2'b01, 2'b00, 0, 0,     0,     0,             0));
    // master 1 read, data one cycle later
    tbl.push_back(v(1, 2'b10, 2'b00, 0,     32'h20, 0,    32'h77, 0,           2'b00, 2'b00, 0, 0,     0,     0,             0));
    tbl.push_back(v(1, 2'b10, 2'b00, 0,     32'h20, 0,    32'h77, 0,           2'b10, 2'b00, 0, 32'h20, 32'h77, 0,          0));
    tbl.push_back(v(1, 2'b00, 2'b00, 0,     32'h20, 0,    32'h77, 32'hDEAD,    2'b10, 2'b10, 0, 0,     0,     0,             32'hDEAD));
    // fairness: both request, 4 accepts each with one idle cycle between
    tbl.push_back(v(1, 2'b11, 2'b11, A0,    A1,    1,     2,    0,             2'b00, 2'b00, 0, 0,     0,     0,             0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(1, 2'b11, 2'b11, A0,  A1,    1,     2,    0,             2'b01, 2'b00, 1, A0,    1,     0,             0));
    tbl.push_back(v(1, 2'b11, 2'b11, A0,    A1,    1,     2,    0,             2'b00, 2'b00, 0, 0,     0,     0,             0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(1, 2'b11, 2'b11, A0,  A1,    1,     2,    0,             2'b10, 2'b00, 1, A1,    2,     0,             0));
    tbl.push_back(v(1, 2'b11, 2'b11, A0,    A1,    1,     2,    0,             2'b00, 2'b00, 0, 0,     0,     0,             0));
    tbl.push_back(v(1, 2'b11, 2'b11, A0,    A1,    1,     2,    0,             2'b01, 2'b00, 1, A0,    1,     0,             0));
    // back-to-back reads by master 0 ending its tenure; last data returns during the switch
    tbl.push_back(v(1, 2'b11, 2'b10, A0,    A1,    1,     2,    32'hC0DE0020,  2'b01, 2'b00, 0, A0,    1,     0,             0));
    tbl.push_back(v(1, 2'b11, 2'b10, A0,    A1,    1,     2,    32'hC0DE0021,  2'b01, 2'b01, 0, A0,    1,     32'hC0DE0021,  0));
    tbl.push_back(v(1, 2'b11, 2'b10, A0,    A1,    1,     2,    32'hC0DE0022,  2'b01, 2'b01, 0, A0,    1,     32'hC0DE0022,  0));
    tbl.push_back(v(1, 2'b11, 2'b11, A0,    A1,    1,     2,    32'hC0DE0023,  2'b00, 2'b01, 0, 0,     0,     32'hC0DE0023,  0));
    tbl.push_back(v(1, 2'b11, 2'b11, A0,    A1,    1,     2,    32'h5555,      2'b10, 2'b00, 1, A1,    2,     0,             0));
    // reset in the cycle after a read accept
    tbl.push_back(v(1, 2'b10, 2'b00, A0,    A1,    1,     2,    0,             2'b10, 2'b00, 0, A1,    2,     0,             0));
    tbl.push_back(v(0, 2'b10, 2'b00, A0,    A1,    1,     2,    32'hBEEF,      2'b00, 2'b00, 0, 0,     0,     0,             0));
    tbl.push_back(v(1, 2'b00, 2'b00, A0,    A1,    1,     2,    32'hBEEF,      2'b00, 2'b00, 0, 0,     0,     0,             0));
    // after reset master 0 wins a simultaneous request
    tbl.push_back(v(1, 2'b11, 2'b11, A0,    A1,    1,     2,    0,             2'b00, 2'b00, 0, 0,     0,     0,             0));
    tbl.push_back(v(1, 2'b11, 2'b11, A0,    A1,    1,     2,    0,             2'b01, 2'b00, 1, A0,    1,     0,             0));
  endtask

  task automatic run_table();
    logic [164:0] got, exp;
    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clk); #1;
      a_rst_n = tbl[r].rst_n;
      a_req   = tbl[r].req;
      a_we    = tbl[r].we;
      a_addr  = {tbl[r].a1, tbl[r].a0};
      a_wd    = {tbl[r].w1, tbl[r].w0};
      a_rd_m  = tbl[r].rdm;
      @(negedge clk);
      got = {a_gnt, a_rv, a_we_m, a_addr_m, a_wd_m, a_rd};
      exp = {tbl[r].gnt, tbl[r].rv, tbl[r].wem, tbl[r].am, tbl[r].wdm, tbl[r].rd1, tbl[r].rd0};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL vec row=%0d gnt=%b/%b rvalid=%b/%b we_m=%b/%b addr_m=%h/%h wd_m=%h/%h rd=%h/%h (got/required)",
                 r, a_gnt, tbl[r].gnt, a_rv, tbl[r].rv, a_we_m, tbl[r].wem, a_addr_m, tbl[r].am,
                 a_wd_m, tbl[r].wdm, a_rd, {tbl[r].rd1, tbl[r].rd0});
      end
    end
  endtask

  // ---------------- transaction-level reference model for DUT B
  bit md_busy = 1'b0;
  int md_own  = 0;
  int md_last = M - 1;
  int md_n    = 0;   // transfers accepted in the current tenure
  int md_ret  = -1;  // master owed read data this cycle, -1 if none

  task automatic step3(input logic rst, input logic [M-1:0] rq, input logic [M-1:0] wv,
                       input logic [MW-1:0] ad, input logic [MW-1:0] wdv,
                       input logic [W-1:0] rdm, input string tag);
    logic [M-1:0]  e_gnt, e_rv;
    logic          e_wem;
    logic [W-1:0]  e_am, e_wdm;
    logic [MW-1:0] e_rd, rdw;
    bit acc, others;
    int nxt_ret;
    @(posedge clk); #1;
    b_rst_n = rst; b_req = rq; b_we = wv; b_addr = ad; b_wd = wdv; b_rd_m = rdm;
    @(negedge clk);
    e_gnt = '0; e_rv = '0; e_wem = 1'b0; e_am = '0; e_wdm = '0; e_rd = '0;
    acc = 1'b0;
    if (rst) begin
      if (md_busy) e_gnt = M'(1) << md_own;
      acc = md_busy && (((rq >> md_own) & 1) != 0);
      if (acc) begin
        e_wem = ((wv >> md_own) & 1) != 0;
        e_am  = W'(ad >> (W * md_own));
        e_wdm = W'(wdv >> (W * md_own));
      end
      if (md_ret >= 0) begin
        rdw  = MW'(rdm);
        e_rv = M'(1) << md_ret;
        e_rd = rdw << (W * md_ret);
      end
    end
    checks++;
    if ({b_gnt, b_rv, b_we_m, b_addr_m, b_wd_m, b_rd} !== {e_gnt, e_rv, e_wem, e_am, e_wdm, e_rd}) begin
      failures++;
      $display("FAIL %s t=%0t gnt=%b/%b rvalid=%b/%b we_m=%b/%b addr_m=%h/%h wd_m=%h/%h rd=%h/%h (got/required)",
               tag, $time, b_gnt, e_gnt, b_rv, e_rv, b_we_m, e_wem, b_addr_m, e_am, b_wd_m, e_wdm, b_rd, e_rd);
    end
    // advance the model across the coming clock edge
    if (!rst) begin
      md_busy = 1'b0; md_own = 0; md_last = M - 1; md_n = 0; md_ret = -1;
    end else begin
      nxt_ret = (acc && (((wv >> md_own) & 1) == 0)) ? md_own : -1;
      if (!md_busy) begin
        for (int k = 1; k <= M; k++) begin
          int j;
          j = (md_last + k) % M;
          if (!md_busy && (((rq >> j) & 1) != 0)) begin
            md_busy = 1'b1; md_own = j; md_last = j; md_n = 0;
          end
        end
      end else if (!acc) begin
        md_busy = 1'b0;
      end else begin
        md_n++;
        others = (rq & ~(M'(1) << md_own)) != '0;
        if (md_n >= H && others) md_busy = 1'b0;
      end
      md_ret = nxt_ret;
    end
  endtask

  // ---------------- main sequence
  initial begin
    logic [M-1:0] cur_req;
    a_rst_n = 1'b0; a_req = '0; a_we = '0; a_addr = '0; a_wd = '0; a_rd_m = '0;
    b_rst_n = 1'b0; b_req = '0; b_we = '0; b_addr = '0; b_wd = '0; b_rd_m = '0;

    fill_table();
    run_table();

    // round robin with 3 masters: owner 1 releases with 0 and 2 waiting -> 2 next
    step3(0, 3'b000, 3'b000, '0, '0, '0, "rr_rst");
    step3(0, 3'b111, 3'b000, '0, '0, '0, "rr_rst");
    step3(1, 3'b010, 3'b010, 48'h0003_0002_0001, 48'h0030_0020_0010, '0, "rr_idle");
    step3(1, 3'b010, 3'b010, 48'h0003_0002_0001, 48'h0030_0020_0010, '0, "rr_own1");
    step3(1, 3'b101, 3'b101, 48'h0003_0002_0001, 48'h0030_0020_0010, '0, "rr_rel");
    step3(1, 3'b101, 3'b101, 48'h0003_0002_0001, 48'h0030_0020_0010, '0, "rr_pick");
    step3(1, 3'b101, 3'b101, 48'h0003_0002_0001, 48'h0030_0020_0010, '0, "rr_own2");
    checks++;
    if (b_gnt !== 3'b100 || b_addr_m !== 16'h0003) begin
      failures++;
      $display("FAIL rr_next gnt=%b addr_m=%h required gnt=100 addr_m=0003", b_gnt, b_addr_m);
    end

    // randomized traffic against the model
    cur_req = '0;
    for (int c = 0; c < 3000; c++) begin
      logic          rst;
      logic [MW-1:0] ad, wdv;
      for (int i = 0; i < M; i++)
        if ($urandom_range(5, 0) == 0) cur_req[i] = ~cur_req[i];
      rst = ($urandom_range(99, 0) != 0);
      ad  = {$urandom(), $urandom()};
      wdv = {$urandom(), $urandom()};
      step3(rst, cur_req, M'($urandom()), ad, wdv, W'($urandom()), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
